// File: rtl/dct_coef_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dct_coef_engine                                               |
// | Purpose  : Computes one 2-D DCT-II coefficient X(k1,k2) over an N x N    |
// |            block streamed in raster order, using an elaboration-time     |
// |            fixed-point cosine basis table and a 2-stage MAC datapath.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module dct_coef_engine #(
  parameter int N           = 8,
  parameter int PIX_W       = 8,
  parameter int FRAC_W      = 10,
  parameter int LEVEL_SHIFT = 0,
  parameter int ACC_W       = PIX_W + FRAC_W + 2 * $clog2(N) + 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [$clog2(N)-1:0]    k1_i,
  input  logic [$clog2(N)-1:0]    k2_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [PIX_W-1:0]        in_pix_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [ACC_W-1:0] out_coef_o,
  output logic                    busy_o
);

  localparam int  LW   = $clog2(N);
  localparam int  TW   = FRAC_W + 1;      // basis entry width, |T| < 2^FRAC_W
  localparam int  CW   = FRAC_W + 2;      // cos_term width after the rounding shift
  localparam int  SW   = PIX_W + 1;       // signed, level-shifted sample width
  localparam int  PW   = SW + CW;         // full product width
  localparam real C_PI = 3.14159265358979323846;

  localparam logic signed [2*TW-1:0] C_HALF =
    {{(2*TW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [SW-1:0] C_SHIFT = {2'b01, {(PIX_W-1){1'b0}}};

  // Basis table T[k][n], packed row-major; entry (k,n) sits at index k*N+n.
  function automatic logic [N*N*TW-1:0] build_tab();
    logic [N*N*TW-1:0] tab;
    real a;
    real v;
    int  r;
    tab = '0;
    for (int k = 0; k < N; k++) begin
      for (int n = 0; n < N; n++) begin
        a = (k == 0) ? $sqrt(1.0 / N) : $sqrt(2.0 / N);
        v = (2.0 ** FRAC_W) * a * $cos(C_PI * real'((2 * n + 1) * k) / real'(2 * N));
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        tab[(k * N + n) * TW +: TW] = r[TW-1:0];
      end
    end
    return tab;
  endfunction

  localparam logic [N*N*TW-1:0] C_TAB = build_tab();

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [LW-1:0]            k1_q, k1_d, k2_q, k2_d;
  logic [LW-1:0]            n1_q, n1_d, n2_q, n2_d;
  logic                     clr_acc, accept;
  logic                     pvld_q;
  logic signed [PW-1:0]     prod_q;
  logic signed [ACC_W-1:0]  acc_q;

  logic signed [TW-1:0]     w_t1, w_t2;
  logic signed [2*TW-1:0]   w_round;
  logic signed [CW-1:0]     w_cos;
  logic signed [SW-1:0]     w_pix_s;
  logic signed [PW-1:0]     w_prod;
  int                       idx1, idx2;

  // Next-state, counter advance and handshake outputs.
  always_comb begin
    state_d     = state_q;
    k1_d        = k1_q;
    k2_d        = k2_q;
    n1_d        = n1_q;
    n2_d        = n2_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    clr_acc     = 1'b0;
    accept      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          k1_d    = k1_i;
          k2_d    = k2_i;
          n1_d    = '0;
          n2_d    = '0;
          clr_acc = 1'b1;
        end
      end
      S_RUN: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          accept = 1'b1;
          n2_d   = n2_q + LW'(1);
          if (n2_q == LW'(N - 1)) begin
            n1_d = n1_q + LW'(1);
            if (n1_q == LW'(N - 1)) begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Basis lookup, rounded cos_term and full-width sample product.
  always_comb begin
    idx1    = int'({k1_q, n1_q}) * TW;
    idx2    = int'({k2_q, n2_q}) * TW;
    w_t1    = signed'(C_TAB[idx1 +: TW]);
    w_t2    = signed'(C_TAB[idx2 +: TW]);
    w_round = (w_t1 * w_t2) + C_HALF;
    w_cos   = CW'(w_round >>> FRAC_W);
    w_pix_s = signed'({1'b0, in_pix_i}) - ((LEVEL_SHIFT != 0) ? C_SHIFT : '0);
    w_prod  = w_pix_s * w_cos;
  end

  // Control state, latched frequency indices and sample counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k1_q    <= '0;
      k2_q    <= '0;
      n1_q    <= '0;
      n2_q    <= '0;
    end else begin
      state_q <= state_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
    end
  end

  // Stage 1 product register and stage 2 exact accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      pvld_q <= 1'b0;
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      pvld_q <= accept;
      if (accept) begin
        prod_q <= w_prod;
      end
      if (clr_acc) begin
        acc_q <= '0;
      end else if (pvld_q) begin
        acc_q <= acc_q + {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
      end
    end
  end

  assign out_coef_o = acc_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/dct_coef_engine.md
DCT_COEF_ENGINE -- requirements
Module: dct_coef_engine

Interface
REQ-001 SHALL have parameter N, default 8, meaning block edge length (power of two, 4..16).
REQ-002 SHALL have parameter PIX_W, default 8, meaning input sample width (unsigned).
REQ-003 SHALL have parameter FRAC_W, default 10, meaning fraction bits of basis terms (Q.FRAC_W).
REQ-004 SHALL have parameter LEVEL_SHIFT, default 0, meaning: 1 subtracts 2^(PIX_W-1) from each sample before multiplying.
REQ-005 SHALL have parameter ACC_W, default PIX_W+FRAC_W+2*log2(N)+3, meaning accumulator/result width (signed).
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 start  in  1  request a new coefficient computation.
REQ-010 k1, k2  in  log2(N) each  frequency indices, sampled when start is accepted.
REQ-011 in_valid / in_ready  in / out  1  sample handshake.
REQ-012 in_pix  in  PIX_W  sample, raster order, n1 (row) major, n2 minor.
REQ-013 out_valid / out_ready  out / in  1  result handshake.
REQ-014 out_coef  out  ACC_W  signed coefficient X(k1,k2).
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 SHALL derive the 1-D table at elaboration: T[k][n] = round_half_away(2^FRAC_W * a(k) * cos(pi*(2n+1)*k/(2N))); a(0)=sqrt(1/N), a(k>0)=sqrt(2/N).
REQ-017 SHALL compute cos_term(n1,n2) = (T[k1][n1]*T[k2][n2] + 2^(FRAC_W-1)) >>> FRAC_W (arithmetic shift; floor); for N=8, FRAC_W=10 this equals the existing fixed k-pair tables bit-exactly.
REQ-018 SHALL use FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-019 IDLE: in_ready=0; start=1 latches k1,k2, clears accumulator and n1/n2 counters, goes to RUN next cycle.
REQ-020 RUN: in_ready=1; each cycle with in_valid&&in_ready consumes one sample, advances n2, wraps n2 N-1->0 with n1 increment; after the N*N-th accepted sample goes to DRAIN, in_ready=0.
REQ-021 in_valid low cycles in RUN SHALL stall counters and contribute nothing.
REQ-022 Datapath SHALL be 2 stages: stage 1 registers (pixel - shift) * cos_term; stage 2 adds into accumulator; product widths full, no truncation.
REQ-023 out_valid SHALL assert exactly 2 cycles after the cycle in which the last sample is accepted (DRAIN lasts 1 cycle, DONE entered).
REQ-024 DONE: out_valid=1, out_coef stable; out_valid&&out_ready returns to IDLE next cycle; out_valid held indefinitely while out_ready=0.
REQ-025 start SHALL be ignored in every state except IDLE; start in the same cycle as DONE handshake is ignored.
REQ-026 Accumulation SHALL be exact two's complement; ACC_W default guarantees no overflow; no saturation.

Reset
REQ-027 rst=1 SHALL force IDLE, out_valid=0, in_ready=0, busy=0, out_coef=0, counters and accumulator 0, pipeline stage valid bits 0, regardless of state (including mid-RUN/DONE).
REQ-028 First start SHALL be accepted in the first cycle after rst deasserts.

Verification
REQ-029 Reset: assert rst 2 cycles in any state -> out_valid=0, in_ready=0, busy=0, out_coef=0.
REQ-030 DC: N=8, LEVEL_SHIFT=0, k=(0,0), 64 samples of 255 back-to-back -> cos_term=128, out_coef=2088960, out_valid exactly 2 cycles after 64th sample.
REQ-031 Table check: k=(4,7), sample 100 at (0,0), others 0 -> out_coef=3500; sample 100 only at (0,3) -> out_coef=-17700.
REQ-032 Stalls/backpressure: random in_valid gaps and out_ready low 10 cycles -> result unchanged, out_valid held, no extra sample consumed.
REQ-033 Protocol: start pulsed during RUN/DONE ignored (k1,k2 unchanged); rst mid-RUN after 30 samples, then new start -> fresh result equal to golden model.
REQ-034 Sweep all 64 (k1,k2) with random blocks, LEVEL_SHIFT 0 and 1, N=4 and 8 -> out_coef equals bit-exact reference model of REQ-016/017.
